uart_tx_dispatch: RTL and testbench

Byte buffer and frame pacer upstream of the UART top level. It accepts bytes from a host write port into a FIFO and feeds the transmitter's `send`/`d_in` inputs. It issues one single-cycle `send` pulse per byte, holds `d_in` stable, then waits a fixed frame-plus-guard interval before issuing the next byte. The transmitter therefore never sees a new `send` while a frame is on the line.

---
 rtl/uart_tx_dispatch.sv | 127 ++++++++++++
 tb/tb_uart_tx_dispatch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_dispatch.sv
// Byte FIFO plus frame pacer in front of the UART transmitter: pops one byte per
// frame, pulses send for one cycle, then holds off for a full frame plus guard time.
module uart_tx_dispatch #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int CLKS_PER_BIT = 434,
  parameter int FRAME_BITS   = 11,
  parameter int GUARD_CLKS   = 434
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              tx_en,
  output logic              send,
  output logic [7:0]        d_in,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              busy
);

  // state  | meaning
  // IDLE   | waiting for tx_en and a stored byte; pops on the exit edge
  // SEND   | send pulse is high, d_in holds the popped byte
  // WAIT   | frame plus guard interval counting down to zero

  localparam int W     = CLKS_PER_BIT * FRAME_BITS + GUARD_CLKS;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam int LVL_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic [7:0]         mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic               wr_acc;
  logic               pop;

  // Both decisions use registered flags, so a write into a full FIFO is
  // rejected even when a pop frees a slot on the same edge.
  assign wr_acc = wr_en && !full && !reset;
  assign pop    = (state == S_IDLE) && tx_en && !empty && !reset;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_acc && !pop) begin
        level <= level + 1'b1;
        full  <= (level == LVL_W'(DEPTH - 1));
        empty <= 1'b0;
      end else if (!wr_acc && pop) begin
        level <= level - 1'b1;
        full  <= 1'b0;
        empty <= (level == LVL_W'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      send     <= 1'b0;
      d_in     <= 8'h00;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          send <= 1'b0;
          if (pop) begin
            d_in  <= mem[rd_ptr];
            send  <= 1'b1;
            busy  <= 1'b1;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          send     <= 1'b0;
          wait_cnt <= CNT_W'(W - 1);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          send <= 1'b0;
          if (wait_cnt == '0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: begin
          send  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_dispatch.sv
// Directed bench for uart_tx_dispatch with a short frame (W = 4*11 + 4 = 48).
module tb_uart_tx_dispatch;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx_en;
  logic       send;
  logic [7:0] d_in;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_tx_dispatch #(
    .DEPTH(16), .ADDR_W(4), .CLKS_PER_BIT(4), .FRAME_BITS(11), .GUARD_CLKS(4)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .tx_en(tx_en),
    .send(send), .d_in(d_in), .full(full), .empty(empty), .level(level),
    .overflow(overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_send(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (send !== 1'b1 && n < max);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic quiet(input int cycles, output int sends);
    sends = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (send === 1'b1) sends++;
    end
  endtask

  initial begin
    int n;
    int s;
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_en = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_send", {31'd0, send}, 32'd0);
    chk("rst_d_in", {24'd0, d_in}, 32'h00);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // single byte
    tx_en = 1'b1; wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    chk("single_level_e0", {27'd0, level}, 32'd1);
    chk("single_empty_e0", {31'd0, empty}, 32'd0);
    chk("single_send_e0", {31'd0, send}, 32'd0);
    tick();
    chk("single_send", {31'd0, send}, 32'd1);
    chk("single_d_in", {24'd0, d_in}, 32'hA5);
    chk("single_empty_pop", {31'd0, empty}, 32'd1);
    chk("single_level_pop", {27'd0, level}, 32'd0);
    n = 1;
    tick();
    chk("single_send_low", {31'd0, send}, 32'd0);
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk("single_busy_len", n, 49);
    chk("single_d_in_hold", {24'd0, d_in}, 32'hA5);

    // burst of three
    wr_en = 1'b1; wr_data = 8'h01;
    tick();
    wr_data = 8'h02;
    tick();
    chk("burst_send1", {31'd0, send}, 32'd1);
    chk("burst_d_in1", {24'd0, d_in}, 32'h01);
    chk("burst_level_e1", {27'd0, level}, 32'd1);
    wr_data = 8'h03;
    tick();
    wr_en = 1'b0;
    chk("burst_level_peak", {27'd0, level}, 32'd2);
    wait_send(60, n);
    chk("burst_gap2", n, 49);
    chk("burst_d_in2", {24'd0, d_in}, 32'h02);
    wait_send(60, n);
    chk("burst_gap3", n, 50);
    chk("burst_d_in3", {24'd0, d_in}, 32'h03);
    chk("burst_empty", {31'd0, empty}, 32'd1);
    wait_idle("burst_idle");

    // fill to full with dispatch disabled; pointers wrap past entry 15
    tx_en = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
      tick();
      if (i == 14) begin
        chk("fill_level15", {27'd0, level}, 32'd15);
        chk("fill_full15", {31'd0, full}, 32'd0);
      end
    end
    chk("fill_full16", {31'd0, full}, 32'd1);
    chk("fill_level16", {27'd0, level}, 32'd16);
    chk("fill_ovf16", {31'd0, overflow}, 32'd0);
    wr_data = 8'h20;
    tick();
    wr_en = 1'b0;
    chk("ovf_pulse", {31'd0, overflow}, 32'd1);
    chk("ovf_level", {27'd0, level}, 32'd16);
    chk("ovf_send", {31'd0, send}, 32'd0);
    tick();
    chk("ovf_pulse_end", {31'd0, overflow}, 32'd0);
    tx_en = 1'b1;
    tick();
    chk("drain_send0", {31'd0, send}, 32'd1);
    chk("drain_d_in0", {24'd0, d_in}, 32'h10);
    chk("drain_full_fall", {31'd0, full}, 32'd0);
    chk("drain_level0", {27'd0, level}, 32'd15);
    for (int i = 1; i < 16; i++) begin
      wait_send(60, n);
      chk("drain_gap", n, 50);
      chk("drain_d_in", {24'd0, d_in}, 32'h10 + i);
    end
    wait_idle("drain_idle");
    quiet(60, s);
    chk("drain_no_extra", s, 0);
    chk("drain_empty", {31'd0, empty}, 32'd1);

    // write on the same edge as a pop
    tx_en = 1'b0; wr_en = 1'b1; wr_data = 8'h31;
    tick();
    chk("sim_level_pre", {27'd0, level}, 32'd1);
    tx_en = 1'b1; wr_data = 8'h32;
    tick();
    wr_en = 1'b0;
    chk("sim_level", {27'd0, level}, 32'd1);
    chk("sim_send", {31'd0, send}, 32'd1);
    chk("sim_d_in", {24'd0, d_in}, 32'h31);
    wait_send(60, n);
    chk("sim_gap", n, 50);
    chk("sim_d_in2", {24'd0, d_in}, 32'h32);
    chk("sim_level_end", {27'd0, level}, 32'd0);
    wait_idle("sim_idle");

    // pause during WAIT
    wr_en = 1'b1; wr_data = 8'h41;
    tick();
    wr_data = 8'h42;
    tick();
    wr_en = 1'b0;
    chk("pause_d_in1", {24'd0, d_in}, 32'h41);
    for (int i = 0; i < 5; i++) tick();
    tx_en = 1'b0;
    quiet(100, s);
    chk("pause_no_send", s, 0);
    chk("pause_busy", {31'd0, busy}, 32'd0);
    chk("pause_level", {27'd0, level}, 32'd1);
    tx_en = 1'b1;
    tick();
    chk("resume_send", {31'd0, send}, 32'd1);
    chk("resume_d_in", {24'd0, d_in}, 32'h42);
    wait_idle("resume_idle");

    // reset mid-frame with bytes queued
    wr_en = 1'b1; wr_data = 8'h51;
    tick();
    wr_data = 8'h52;
    tick();
    wr_data = 8'h53;
    tick();
    wr_data = 8'h54;
    tick();
    wr_en = 1'b0;
    chk("mid_level", {27'd0, level}, 32'd3);
    for (int i = 0; i < 8; i++) tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_send", {31'd0, send}, 32'd0);
    chk("mid_rst_d_in", {24'd0, d_in}, 32'h00);
    chk("mid_rst_empty", {31'd0, empty}, 32'd1);
    chk("mid_rst_level", {27'd0, level}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    quiet(120, s);
    chk("mid_rst_no_send", s, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
